// File: rtl/fetch_decode_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_decode_queue_if
//
// Purpose : Bundles the fetch-side and decode-side signals of the
//           fetch/decode instruction queue into one interface.
//
// Modports:
//   slave  - the queue itself (samples fetch_* and dec_ready_in, drives the
//            decode view, the field slices and the occupancy count)
//   master - the environment (fetch stage + decode unit) around the queue
//
// Signals:
//   fetch_valid_in     fetch presents an instruction
//   fetch_ready_out    queue accepts a push this cycle (= !full)
//   fetch_ins_in       fetched instruction word        [XLEN]
//   fetch_pc_in        PC of the fetched instruction   [XLEN]
//   dec_valid_out      head entry is valid (= !empty)
//   dec_ready_in       decode consumes the head this cycle
//   dec_ins_out        head instruction, NOP when empty [XLEN]
//   dec_pc_out         head PC, 0 when empty           [XLEN]
//   opcode_out .. rd_out  pre-split fields of dec_ins_out
//   ins_len_fault_out  head is a compressed (16-bit) encoding
//   count_out          current occupancy               [clog2(DEPTH)+1]
// ----------------------------------------------------------------------------
interface fetch_decode_queue_if #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            fetch_valid_in;
   logic            fetch_ready_out;
   logic [XLEN-1:0] fetch_ins_in;
   logic [XLEN-1:0] fetch_pc_in;

   logic            dec_valid_out;
   logic            dec_ready_in;
   logic [XLEN-1:0] dec_ins_out;
   logic [XLEN-1:0] dec_pc_out;
   logic [4:0]      opcode_out;
   logic [2:0]      funct3_out;
   logic [6:0]      funct7_out;
   logic [4:0]      rs1_out;
   logic [4:0]      rs2_out;
   logic [4:0]      rd_out;
   logic            ins_len_fault_out;
   logic [CW-1:0]   count_out;

   modport slave (
      input  fetch_valid_in, fetch_ins_in, fetch_pc_in, dec_ready_in,
      output fetch_ready_out, dec_valid_out, dec_ins_out, dec_pc_out,
             opcode_out, funct3_out, funct7_out, rs1_out, rs2_out, rd_out,
             ins_len_fault_out, count_out
   );

   modport master (
      output fetch_valid_in, fetch_ins_in, fetch_pc_in, dec_ready_in,
      input  fetch_ready_out, dec_valid_out, dec_ins_out, dec_pc_out,
             opcode_out, funct3_out, funct7_out, rs1_out, rs2_out, rd_out,
             ins_len_fault_out, count_out
   );
endinterface

// File: rtl/fetch_decode_queue.sv
// ----------------------------------------------------------------------------
// fetch_decode_queue
//
// Purpose : Instruction queue between fetch and decode. Buffers up to DEPTH
//           {pc, instruction} pairs, presents the oldest one to decode with
//           its RISC-V fields pre-split, absorbs decode stalls and drops all
//           contents on a pipeline flush.
//
//           First-word fall-through without bypass: an entry pushed into an
//           empty queue is visible on the decode side one cycle later, and no
//           combinational path exists from the fetch inputs to the decode
//           outputs.
//
// Ports:
//   clock_in   single clock, rising edge
//   reset_in   asynchronous, active-high reset
//   flush_in   synchronous flush; empties the queue at the next edge and
//              discards any push/pop of that cycle
//   bus        fetch_decode_queue_if.slave (fetch handshake, decode view,
//              field slices, length fault, occupancy)
// ----------------------------------------------------------------------------
module fetch_decode_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                 clock_in,
   input  logic                 reset_in,
   input  logic                 flush_in,
   fetch_decode_queue_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [XLEN-1:0] NOP_INS = XLEN'(32'h0000_0013);

   // Pointer wrap relies on DEPTH being a power of two.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("fetch_decode_queue: DEPTH must be a power of two >= 2");
   end

   logic [XLEN-1:0] ins_mem [DEPTH];
   logic [XLEN-1:0] pc_mem  [DEPTH];

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic push;
   logic pop;

   logic [XLEN-1:0] head_ins;
   logic [XLEN-1:0] head_pc;

   // Status comes only from the registered count, so ready/valid never
   // depend combinationally on the opposite side of the queue.
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A full queue refuses a push even when a pop happens in the same cycle;
   // ready reappears only once the lower count has been registered.
   assign push = bus.fetch_valid_in && !full;
   assign pop  = bus.dec_ready_in   && !empty;

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others.
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush_in) begin
         // Flush wins over any handshake in the same cycle.
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; its contents are never visible
   // while the count says the slot is empty, so resetting it would only cost
   // flops and routing.
   always_ff @(posedge clock_in) begin
      if (push && !flush_in) begin
         ins_mem[wr_ptr] <= bus.fetch_ins_in;
         pc_mem[wr_ptr]  <= bus.fetch_pc_in;
      end
   end

   // NOTE: every signal driven from always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      head_ins = NOP_INS;
      head_pc  = '0;
      if (!empty) begin
         head_ins = ins_mem[rd_ptr];
         head_pc  = pc_mem[rd_ptr];
      end
   end

   assign bus.fetch_ready_out = !full;
   assign bus.dec_valid_out   = !empty;
   assign bus.dec_ins_out     = head_ins;
   assign bus.dec_pc_out      = head_pc;
   assign bus.count_out       = count;

   // Field slices follow dec_ins_out, so an empty queue decodes as the NOP.
   assign bus.opcode_out = head_ins[6:2];
   assign bus.funct3_out = head_ins[14:12];
   assign bus.funct7_out = head_ins[31:25];
   assign bus.rs1_out    = head_ins[19:15];
   assign bus.rs2_out    = head_ins[24:20];
   assign bus.rd_out     = head_ins[11:7];

   // Compressed encodings (low bits != 2'b11) are not supported downstream.
   assign bus.ins_len_fault_out = !empty && (head_ins[1:0] != 2'b11);

endmodule
